vga_fb_arbiter: RTL and testbench

Shares one single-port, double-banked 2-bit-per-pixel frame memory between the camera write path and the VGA scan-out read path. It schedules fixed display-read slots from h_count/v_count and delivers the pixel code on `data`, which drives vga_display. Camera writes run in all remaining cycles. The block also sequences front/back bank swaps at the frame boundary.

---
 rtl/vga_fb_pkg.sv | 32 +++
 rtl/vga_fb_addr_gen.sv | 15 +
 rtl/vga_fb_arbiter.sv | 113 +++++++++++
 tb/tb_vga_fb_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_fb_pkg.sv
// Shared constants and types for the VGA frame-buffer arbiter: screen timing, frame-buffer
// geometry, pixel codes and the bank-swap state encoding.
package vga_fb_pkg;

  localparam int unsigned FB_W     = 160;
  localparam int unsigned FB_H     = 120;
  localparam int unsigned H_ACT0   = 160;
  localparam int unsigned V_ACT0   = 41;
  localparam int unsigned H_TOTAL  = 800;
  localparam int unsigned V_TOTAL  = 521;
  localparam int unsigned PREFETCH = 4;

  localparam int unsigned FB_PIXELS = FB_W * FB_H;

  // Each frame-buffer pixel covers 4 screen columns; reads run PREFETCH cycles ahead.
  localparam int unsigned SLOT_H_FIRST = H_ACT0 - PREFETCH;
  localparam int unsigned SLOT_H_LAST  = H_ACT0 + 4 * FB_W - 4 - PREFETCH;
  localparam int unsigned V_ACT_LAST   = V_ACT0 + 4 * FB_H - 1;

  typedef enum logic [1:0] {
    PixBlack = 2'b00,
    PixDark  = 2'b01,
    PixLight = 2'b10,
    PixWhite = 2'b11
  } pix_code_e;

  typedef enum logic {
    StIdle,
    StPending
  } swap_state_e;

endpackage

// File: rtl/vga_fb_addr_gen.sv
// Combinational (row, col) to linear frame-buffer address, row*160 done as shift-add,
// with a flag telling whether the coordinate lies inside the frame buffer.
module vga_fb_addr_gen
  import vga_fb_pkg::*;
(
  input  logic [6:0]  row,
  input  logic [7:0]  col,
  output logic [14:0] addr,
  output logic        in_range
);

  assign addr     = (15'(row) << 7) + (15'(row) << 5) + 15'(col);
  assign in_range = (row < 7'(FB_H)) && (col < 8'(FB_W));

endmodule

// File: rtl/vga_fb_arbiter.sv
// Time-shares a single-port double-banked frame memory between VGA scan-out reads (fixed
// slots) and camera writes, and swaps front/back banks at the frame boundary.
module vga_fb_arbiter
  import vga_fb_pkg::*;
(
  input  logic        clk_25,
  input  logic        rst,
  input  logic [9:0]  h_count,
  input  logic [9:0]  v_count,
  input  logic        wr_valid,
  input  logic [14:0] wr_addr,
  input  logic [1:0]  wr_data,
  output logic        wr_ready,
  input  logic        frame_done,
  output logic        swap_ack,
  output logic        front_bank,
  output logic [15:0] mem_addr,
  output logic        mem_we,
  output logic [1:0]  mem_wdata,
  input  logic [1:0]  mem_rdata,
  output logic [1:0]  data
);

  logic [9:0]  h_off, v_off;
  logic [6:0]  row;
  logic [7:0]  col;
  logic [14:0] rd_addr;
  logic        rd_in_range;
  logic        row_act, slot, capture, transfer, boundary;
  logic        wr_accept, wr_in_range;
  logic [15:0] mem_addr_q;
  logic [1:0]  hold_q;
  swap_state_e state_q;

  assign h_off = h_count - 10'(SLOT_H_FIRST);
  assign v_off = v_count - 10'(V_ACT0);
  assign row   = 7'(v_off >> 2);
  assign col   = 8'(h_off >> 2);

  vga_fb_addr_gen u_rd_addr (
    .row      (row),
    .col      (col),
    .addr     (rd_addr),
    .in_range (rd_in_range)
  );

  assign row_act = (v_count >= 10'(V_ACT0)) && (v_count <= 10'(V_ACT_LAST));
  assign slot    = row_act && (h_count >= 10'(SLOT_H_FIRST)) && (h_count <= 10'(SLOT_H_LAST))
                   && (h_count[1:0] == 2'b00) && rd_in_range;
  // Memory data returns one cycle after the slot; it reaches the pins two cycles later.
  assign capture  = row_act && (h_count >= 10'(SLOT_H_FIRST + 1))
                    && (h_count <= 10'(SLOT_H_LAST + 1)) && (h_count[1:0] == 2'b01);
  assign transfer = row_act && (h_count >= 10'(SLOT_H_FIRST + 3))
                    && (h_count <= 10'(SLOT_H_LAST + 3)) && (h_count[1:0] == 2'b11);
  assign boundary = (h_count == 10'(H_TOTAL - 1)) && (v_count == 10'(V_TOTAL - 1));

  assign wr_ready    = ~slot && (state_q == StIdle);
  assign wr_accept   = wr_valid && wr_ready;
  assign wr_in_range = wr_addr < 15'(FB_PIXELS);

  always_comb begin
    mem_addr  = mem_addr_q;
    mem_we    = 1'b0;
    mem_wdata = PixBlack;
    if (slot) begin
      mem_addr = {front_bank, rd_addr};
    end else if (wr_accept) begin
      mem_addr  = {~front_bank, wr_addr};
      mem_we    = wr_in_range;
      mem_wdata = wr_data;
    end
  end

  always_ff @(posedge clk_25 or posedge rst) begin
    if (rst) begin
      mem_addr_q <= '0;
      hold_q     <= PixBlack;
      data       <= PixBlack;
    end else begin
      if (slot || wr_accept) mem_addr_q <= mem_addr;
      if (capture) hold_q <= mem_rdata;
      if (h_count == 10'(H_TOTAL - 1)) begin
        data <= PixBlack;
      end else if (transfer) begin
        data <= hold_q;
      end
    end
  end

  always_ff @(posedge clk_25 or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      front_bank <= 1'b0;
      swap_ack   <= 1'b0;
    end else begin
      swap_ack <= 1'b0;
      case (state_q)
        StIdle: begin
          if (frame_done) state_q <= StPending;
        end
        StPending: begin
          if (boundary) begin
            front_bank <= ~front_bank;
            swap_ack   <= 1'b1;
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: directed vector table, hand-written swap/reset sequences and
// randomized traffic, all checked against a behavioural model of the arbiter.
module tb_vga_fb_arbiter;

  logic        clk_25 = 1'b0;
  logic        rst;
  logic [9:0]  h_count, v_count;
  logic        wr_valid, frame_done;
  logic [14:0] wr_addr;
  logic [1:0]  wr_data, mem_rdata;
  logic        wr_ready, swap_ack, front_bank, mem_we;
  logic [15:0] mem_addr;
  logic [1:0]  mem_wdata, data;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_25 = ~clk_25;

  vga_fb_arbiter dut (
    .clk_25     (clk_25),
    .rst        (rst),
    .h_count    (h_count),
    .v_count    (v_count),
    .wr_valid   (wr_valid),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .frame_done (frame_done),
    .swap_ack   (swap_ack),
    .front_bank (front_bank),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .data       (data)
  );

  // Behavioural model, evaluated on the falling edge while inputs are stable.
  logic [1:0]  m_data, m_hold;
  logic        m_fb, m_pend, m_ack;
  logic [15:0] m_last;

  always @(negedge clk_25) begin : model
    int unsigned h, v;
    logic        active, slot, acc, e_we, e_ready;
    logic [15:0] e_addr;
    logic [1:0]  c_data, c_hold;
    logic        c_fb, c_pend, c_ack;
    logic [15:0] c_last;
    h      = h_count;
    v      = v_count;
    c_data = rst ? 2'b00 : m_data;
    c_hold = rst ? 2'b00 : m_hold;
    c_fb   = rst ? 1'b0 : m_fb;
    c_pend = rst ? 1'b0 : m_pend;
    c_ack  = rst ? 1'b0 : m_ack;
    c_last = rst ? 16'h0 : m_last;
    active  = (v >= 41) && (v <= 520);
    slot    = active && (h >= 156) && (h <= 792) && (h % 4 == 0);
    e_ready = !slot && !c_pend;
    acc     = wr_valid && e_ready;
    e_we    = 1'b0;
    if (slot) begin
      e_addr = {c_fb, 15'(((v - 41) / 4) * 160 + (h - 156) / 4)};
    end else if (acc) begin
      e_addr = {~c_fb, wr_addr};
      e_we   = (wr_addr < 15'd19200);
    end else begin
      e_addr = c_last;
    end
    n_tests++;
    if (mem_addr !== e_addr || mem_we !== e_we || wr_ready !== e_ready || data !== c_data ||
        front_bank !== c_fb || swap_ack !== c_ack || (e_we && mem_wdata !== wr_data)) begin
      n_fail++;
      $display("FAIL model t=%0t h=%0d v=%0d (got/exp): addr %h/%h we %b/%b ready %b/%b data %h/%h fb %b/%b ack %b/%b wdata %h/%h",
               $time, h, v, mem_addr, e_addr, mem_we, e_we, wr_ready, e_ready, data, c_data,
               front_bank, c_fb, swap_ack, c_ack, mem_wdata, wr_data);
    end
    if (rst) begin
      m_data <= 2'b00; m_hold <= 2'b00; m_fb <= 1'b0; m_pend <= 1'b0; m_ack <= 1'b0;
      m_last <= 16'h0;
    end else begin
      m_last <= (slot || acc) ? e_addr : c_last;
      if (h == 799) m_data <= 2'b00;
      else if (active && h % 4 == 3 && h >= 159 && h <= 795) m_data <= c_hold;
      else m_data <= c_data;
      m_hold <= (active && h % 4 == 1 && h >= 157 && h <= 793) ? mem_rdata : c_hold;
      m_ack  <= 1'b0;
      m_fb   <= c_fb;
      m_pend <= c_pend;
      if (c_pend && h == 799 && v == 520) begin
        m_fb <= ~c_fb; m_ack <= 1'b1; m_pend <= 1'b0;
      end else if (!c_pend && frame_done) begin
        m_pend <= 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: drive just after the rising edge, return at the falling edge for checking.
  task automatic cyc(input int h, input int v, input bit r, input bit wv, input int wa,
                     input int wd, input bit fd, input int rd);
    @(posedge clk_25);
    #1;
    h_count = 10'(h); v_count = 10'(v); rst = r; wr_valid = wv; wr_addr = 15'(wa);
    wr_data = 2'(wd); frame_done = fd; mem_rdata = 2'(rd);
    @(negedge clk_25);
  endtask

  typedef struct {
    int h; int v; bit wv; int wa; int wd; int rd;
    int e_addr; int e_we; int e_ready; int e_data;
  } vec_t;

  vec_t tbl[18];

  initial begin
    int h, v;
    tbl[0]  = '{155, 41, 0, 0, 0, 0, 'h0000, 0, 1, 0};
    tbl[1]  = '{156, 41, 0, 0, 0, 0, 'h0000, 0, 0, 0};
    tbl[2]  = '{157, 41, 0, 0, 0, 2, 'h0000, 0, 1, 0};
    tbl[3]  = '{158, 41, 0, 0, 0, 0, 'h0000, 0, 1, 0};
    tbl[4]  = '{159, 41, 0, 0, 0, 0, 'h0000, 0, 1, 0};
    tbl[5]  = '{160, 41, 0, 0, 0, 0, 'h0001, 0, 0, 2};
    tbl[6]  = '{161, 41, 0, 0, 0, 1, 'h0001, 0, 1, 2};
    tbl[7]  = '{162, 41, 0, 0, 0, 0, 'h0001, 0, 1, 2};
    tbl[8]  = '{163, 41, 0, 0, 0, 0, 'h0001, 0, 1, 2};
    tbl[9]  = '{164, 41, 1, 5, 3, 0, 'h0002, 0, 0, 1};
    tbl[10] = '{165, 41, 1, 5, 3, 0, 'h8005, 1, 1, 1};
    tbl[11] = '{166, 41, 0, 0, 0, 0, 'h8005, 0, 1, 1};
    tbl[12] = '{799, 41, 0, 0, 0, 0, 'h8005, 0, 1, 1};
    tbl[13] = '{0, 42, 0, 0, 0, 0, 'h8005, 0, 1, 0};
    tbl[14] = '{160, 45, 0, 0, 0, 0, 'h00A1, 0, 0, 0};
    tbl[15] = '{170, 45, 1, 19200, 1, 0, 'hCB00, 0, 1, 0};
    tbl[16] = '{792, 520, 0, 0, 0, 0, 'h4AFF, 0, 0, 0};
    tbl[17] = '{796, 520, 0, 0, 0, 0, 'h4AFF, 0, 1, 0};

    rst = 1'b1; h_count = '0; v_count = '0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    frame_done = 1'b0; mem_rdata = '0;
    cyc(0, 0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("reset.data", 16'(data), 16'h0);
    chk("reset.front_bank", 16'(front_bank), 16'h0);
    chk("reset.swap_ack", 16'(swap_ack), 16'h0);
    chk("reset.wr_ready", 16'(wr_ready), 16'h1);

    foreach (tbl[i]) begin
      cyc(tbl[i].h, tbl[i].v, 0, tbl[i].wv, tbl[i].wa, tbl[i].wd, 0, tbl[i].rd);
      chk($sformatf("vec%0d.mem_addr", i), mem_addr, 16'(tbl[i].e_addr));
      chk($sformatf("vec%0d.mem_we", i), 16'(mem_we), 16'(tbl[i].e_we));
      chk($sformatf("vec%0d.wr_ready", i), 16'(wr_ready), 16'(tbl[i].e_ready));
      chk($sformatf("vec%0d.data", i), 16'(data), 16'(tbl[i].e_data));
    end

    // Swap: stall while pending, bank flip and one-cycle ack at the boundary.
    cyc(170, 300, 0, 0, 0, 0, 1, 0);
    chk("swap.ready_before", 16'(wr_ready), 16'h1);
    cyc(171, 300, 0, 1, 7, 2, 0, 0);
    chk("swap.stall_ready", 16'(wr_ready), 16'h0);
    chk("swap.stall_we", 16'(mem_we), 16'h0);
    cyc(799, 520, 0, 1, 7, 2, 0, 0);
    chk("swap.pre_fb", 16'(front_bank), 16'h0);
    cyc(0, 0, 0, 1, 7, 2, 0, 0);
    chk("swap.fb", 16'(front_bank), 16'h1);
    chk("swap.ack", 16'(swap_ack), 16'h1);
    chk("swap.wr_addr_bank0", mem_addr, 16'h0007);
    chk("swap.wr_we", 16'(mem_we), 16'h1);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    chk("swap.ack_drop", 16'(swap_ack), 16'h0);

    // Load a non-zero pixel, then reset while pending with front_bank=1.
    cyc(157, 100, 0, 0, 0, 0, 0, 3);
    cyc(159, 100, 0, 0, 0, 0, 0, 0);
    cyc(160, 100, 0, 0, 0, 0, 0, 0);
    chk("pre_rst.data", 16'(data), 16'h3);
    cyc(170, 300, 0, 0, 0, 0, 1, 0);
    cyc(171, 300, 0, 0, 0, 0, 0, 0);
    chk("rst.pending_ready", 16'(wr_ready), 16'h0);
    cyc(172, 300, 1, 0, 0, 0, 0, 0);
    chk("rst.async_fb", 16'(front_bank), 16'h0);
    chk("rst.async_data", 16'(data), 16'h0);
    cyc(173, 300, 0, 0, 0, 0, 0, 0);
    chk("rst.ready_after", 16'(wr_ready), 16'h1);
    cyc(799, 520, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst.no_swap_fb", 16'(front_bank), 16'h0);
    chk("rst.no_swap_ack", 16'(swap_ack), 16'h0);

    // Double frame_done yields a single swap; frame_done on the boundary defers a frame.
    cyc(170, 300, 0, 0, 0, 0, 1, 0);
    cyc(171, 300, 0, 0, 0, 0, 1, 0);
    cyc(799, 520, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("dbl.fb", 16'(front_bank), 16'h1);
    chk("dbl.ack", 16'(swap_ack), 16'h1);
    cyc(799, 520, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("dbl.single_fb", 16'(front_bank), 16'h1);
    chk("dbl.single_ack", 16'(swap_ack), 16'h0);
    cyc(799, 520, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("edge_fd.fb", 16'(front_bank), 16'h1);
    chk("edge_fd.ready", 16'(wr_ready), 16'h0);
    cyc(799, 520, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("edge_fd.swap_fb", 16'(front_bank), 16'h0);
    chk("edge_fd.swap_ack", 16'(swap_ack), 16'h1);

    // Randomized traffic, checked by the model only.
    h = 150; v = 41;
    for (int n = 0; n < 6000; n++) begin
      int wa, sel;
      if ($urandom_range(0, 199) == 0) begin
        h = $urandom_range(780, 799); v = $urandom_range(510, 520);
      end else if ($urandom_range(0, 399) == 0) begin
        h = $urandom_range(0, 1023); v = $urandom_range(0, 1023);
      end else begin
        h++;
        if (h >= 800) begin
          h = 0; v++;
          if (v >= 521) v = 0;
        end
      end
      sel = $urandom_range(0, 7);
      wa  = (sel == 0) ? $urandom_range(19190, 19210) :
            (sel == 1) ? $urandom_range(0, 32767) : $urandom_range(0, 19199);
      cyc(h, v, $urandom_range(0, 999) == 0, $urandom_range(0, 1) == 1, wa,
          $urandom_range(0, 3), $urandom_range(0, 299) == 0, $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
